// File: rtl/rice_core_pkg.sv
// rice_core_pkg: shared types and helpers for the rice core pipeline controller.
// Holds the controller FSM state encoding, the stall-cause encoding and the
// register-compare helper used by the hazard detector.
package rice_core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [2:0] {
    STATE_RUN,
    STATE_MEM_WAIT,
    STATE_LOAD_USE,
    STATE_DRAIN,
    STATE_REDIRECT
  } rice_pipeline_ctrl_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_LOAD_USE,
    CAUSE_MEM_WAIT
  } rice_pipeline_stall_cause_e;

  // True when a source register depends on the destination; x0 never creates a dependency.
  function automatic logic reg_depends(input logic [REG_ADDR_W-1:0] rd,
                                       input logic [REG_ADDR_W-1:0] rs);
    return (rd != REG_ZERO) && (rd == rs);
  endfunction

endpackage

// File: rtl/rice_core_hazard_detector.sv
// rice_core_hazard_detector: combinational load-use hazard check.
// Flags when the instruction in EX is a load whose destination is read by
// the valid instruction in ID (rs1 or rs2), with x0 masked out.
module rice_core_hazard_detector
  import rice_core_pkg::*;
(
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  load_use
);

  // Load-use compare of both ID sources against the EX load destination.
  always_comb begin
    load_use = 1'b0;
    if (ex_valid && ex_load && id_valid) begin
      load_use = reg_depends(ex_rd, id_rs1) || reg_depends(ex_rd, id_rs2);
    end
  end

endmodule

// File: rtl/rice_core_pipeline_controller.sv
// rice_core_pipeline_controller: stall/flush/redirect sequencer for the
// rice core IF/ID/EX/WB pipeline.
// Optional macro RICE_PIPELINE_CTRL_PERF_EN adds saturating performance
// counters o_stall_cycles and o_flush_count; without it those ports and
// counters do not exist and behaviour is otherwise identical.
module rice_core_pipeline_controller
  import rice_core_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REDIRECT_QUEUE = 0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_id_valid,
  input  logic [4:0]      i_id_rs1,
  input  logic [4:0]      i_id_rs2,
  input  logic            i_ex_valid,
  input  logic            i_ex_load,
  input  logic [4:0]      i_ex_rd,
  input  logic            i_ex_mem_busy,
  input  logic            i_ex_redirect,
  input  logic [XLEN-1:0] i_ex_redirect_pc,
  input  logic            i_inst_request_issued,
  input  logic            i_inst_request_ack,
  output logic            o_stall,
  output logic            o_flush,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  input  logic            i_redirect_ready
`ifdef RICE_PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0]     o_stall_cycles,
  output logic [31:0]     o_flush_count
`endif
);

  // With overwrite enabled a newer EX redirect replaces the pending target.
  localparam bit OVERWRITE = (REDIRECT_QUEUE == 0);

  rice_pipeline_ctrl_state_e  state;
  rice_pipeline_ctrl_state_e  next_state;
  rice_pipeline_stall_cause_e stall_cause;

  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] next_redirect_pc;
  logic            flush_pending;
  logic            next_flush_pending;

  logic load_use;
  logic ex_redirect;
  logic fetch_in_flight;
  logic redirect_accept;

  rice_core_hazard_detector u_hazard (
    .id_valid (i_id_valid),
    .id_rs1   (i_id_rs1),
    .id_rs2   (i_id_rs2),
    .ex_valid (i_ex_valid),
    .ex_load  (i_ex_load),
    .ex_rd    (i_ex_rd),
    .load_use (load_use)
  );

  assign ex_redirect     = i_ex_valid && i_ex_redirect;
  assign fetch_in_flight = i_inst_request_issued && !i_inst_request_ack;
  assign redirect_accept = (state == STATE_REDIRECT) && i_redirect_ready;

  // State, pending redirect target and first-REDIRECT-cycle flag; reset drops any pending redirect.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= STATE_RUN;
      redirect_pc   <= '0;
      flush_pending <= 1'b0;
    end else begin
      state         <= next_state;
      redirect_pc   <= next_redirect_pc;
      flush_pending <= next_flush_pending;
    end
  end

  // Next-state, redirect capture and Moore outputs decoded from the current state.
  always_comb begin
    next_state         = state;
    next_redirect_pc   = redirect_pc;
    next_flush_pending = 1'b0;
    stall_cause        = CAUSE_NONE;
    o_flush            = 1'b0;
    o_redirect_valid   = 1'b0;

    unique case (state)
      STATE_RUN: begin
        if (ex_redirect) begin
          next_redirect_pc = i_ex_redirect_pc;
          if (fetch_in_flight) begin
            next_state = STATE_DRAIN;
          end else begin
            next_state         = STATE_REDIRECT;
            next_flush_pending = 1'b1;
          end
        end else if (i_ex_mem_busy) begin
          next_state = STATE_MEM_WAIT;
        end else if (load_use) begin
          next_state = STATE_LOAD_USE;
        end
      end

      STATE_MEM_WAIT: begin
        stall_cause = CAUSE_MEM_WAIT;
        if (!i_ex_mem_busy) begin
          next_state = STATE_RUN;
        end
      end

      STATE_LOAD_USE: begin
        stall_cause = CAUSE_LOAD_USE;
        next_state  = STATE_RUN;
      end

      STATE_DRAIN: begin
        if (OVERWRITE && ex_redirect) begin
          next_redirect_pc = i_ex_redirect_pc;
        end
        if (i_inst_request_ack) begin
          next_state         = STATE_REDIRECT;
          next_flush_pending = 1'b1;
        end
      end

      STATE_REDIRECT: begin
        o_redirect_valid = 1'b1;
        o_flush          = flush_pending;
        if (redirect_accept) begin
          // A redirect landing in the accept cycle starts a fresh sequence rather than being lost.
          if (OVERWRITE && ex_redirect) begin
            next_redirect_pc = i_ex_redirect_pc;
            if (fetch_in_flight) begin
              next_state = STATE_DRAIN;
            end else begin
              next_state         = STATE_REDIRECT;
              next_flush_pending = 1'b1;
            end
          end else begin
            next_state = STATE_RUN;
          end
        end else if (OVERWRITE && ex_redirect) begin
          // Retarget the offer in place; the flush for this sequence has already been issued.
          next_redirect_pc = i_ex_redirect_pc;
        end
      end

      default: begin
        next_state = STATE_RUN;
      end
    endcase
  end

  assign o_stall       = (stall_cause != CAUSE_NONE);
  assign o_redirect_pc = redirect_pc;

`ifdef RICE_PIPELINE_CTRL_PERF_EN
  // Saturating counts of stalled cycles and flush pulses.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_stall_cycles <= '0;
      o_flush_count  <= '0;
    end else begin
      if (o_stall && (o_stall_cycles != 32'hFFFF_FFFF)) begin
        o_stall_cycles <= o_stall_cycles + 32'd1;
      end
      if (o_flush && (o_flush_count != 32'hFFFF_FFFF)) begin
        o_flush_count <= o_flush_count + 32'd1;
      end
    end
  end
`endif

endmodule
